// File: rtl/uart_rx_core_pkg.sv
// uart_rx_core_pkg: receiver FSM encodings, controller register address
// and the baud divider helper shared by the UART receive path.
package uart_rx_core_pkg;

  localparam logic [3:0] RX_IDLE   = 4'd0;
  localparam logic [3:0] RX_START  = 4'd1;
  localparam logic [3:0] RX_DATA   = 4'd2;
  localparam logic [3:0] RX_PARITY = 4'd3;
  localparam logic [3:0] RX_STOP   = 4'd4;
  localparam logic [3:0] RX_BREAK  = 4'd5;

  localparam logic [31:0] UART_DATA_ADDR = 32'hBFD003F8;

  typedef enum logic [3:0] {
    ST_IDLE   = RX_IDLE,
    ST_START  = RX_START,
    ST_DATA   = RX_DATA,
    ST_PARITY = RX_PARITY,
    ST_STOP   = RX_STOP,
    ST_BREAK  = RX_BREAK
  } rx_state_e;

  function automatic int unsigned calc_div(
    input int unsigned clk_hz,
    input int unsigned baud,
    input int unsigned ovs
  );
    int unsigned per;
    int unsigned d;
    per = baud * ovs;
    d   = (clk_hz + per / 2) / per;
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte FIFO with exact occupancy
// and a dropped-push strobe; power-of-two depth so pointers wrap freely.
module uart_rx_fifo
  import uart_rx_core_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full, empty;
  logic          do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty;
  // A pop in the same cycle frees the slot, so a full push is still legal.
  assign do_push = push_i && (!full || do_pop);
  assign drop_o  = push_i && full && !do_pop;
  assign data_o  = empty ? '0 : mem_q[rd_q];
  assign count_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling 8N1 receiver feeding a FWFT FIFO.
// Define UART_RX_PARITY_EN for an even-parity bit and parity_err flag.
module uart_rx_core
  import uart_rx_core_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rxd,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [7:0]                    rd_data,
  output logic                          data_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic                          parity_err
`endif
);

  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] SC_LO   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SC_M    = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] SC_HI   = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] SC_LAST = SW'(OVERSAMPLE - 1);

  rx_state_e     state_q, state_d;
  logic [1:0]    sync_q;
  logic [DW-1:0] div_q, div_d;
  logic [SW-1:0] sc_q, sc_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [1:0]    smp_q, smp_d;
  logic          ferr_q, ferr_d, ferr_set;
  logic          ovr_q, ovr_d;
  logic          rxs, tick, mid, last, maj;
  logic          push, fifo_drop;
`ifdef UART_RX_PARITY_EN
  logic          pbad_q, pbad_d;
  logic          perr_q, perr_d, perr_set;
`endif

  assign rxs  = sync_q[1];
  assign tick = (div_q == DW'(DIV - 1));
  assign mid  = tick && (sc_q == SC_HI);
  assign last = tick && (sc_q == SC_LAST);
  assign maj  = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs) | (smp_q[1] & rxs);

  always_comb begin
    state_d  = state_q;
    div_d    = tick ? '0 : div_q + 1'b1;
    sc_d     = sc_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    smp_d    = smp_q;
    push     = 1'b0;
    ferr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbad_d   = pbad_q;
    perr_set = 1'b0;
`endif
    if (state_q != ST_IDLE && tick) begin
      sc_d = last ? '0 : sc_q + 1'b1;
      if (sc_q == SC_LO) smp_d[0] = rxs;
      if (sc_q == SC_M)  smp_d[1] = rxs;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (!rxs) begin
          state_d = ST_START;
          sc_d    = '0;
          div_d   = '0;
`ifdef UART_RX_PARITY_EN
          pbad_d  = 1'b0;
`endif
        end
      end
      ST_START: begin
        if (mid && maj) begin
          state_d = ST_IDLE;
        end else if (last) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (mid) shift_d = {maj, shift_q[7:1]};
        if (last) begin
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (mid && (maj != ^shift_q)) begin
          pbad_d   = 1'b1;
          perr_set = 1'b1;
        end
        if (last) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        // Leave half a bit early so a back-to-back start edge is not missed.
        if (mid) begin
          if (maj) begin
`ifdef UART_RX_PARITY_EN
            push    = !pbad_q;
`else
            push    = 1'b1;
`endif
            state_d = ST_IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rxs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ferr_d = ferr_set | (ferr_q & ~clr_err);
  assign ovr_d  = fifo_drop | (ovr_q & ~clr_err);
`ifdef UART_RX_PARITY_EN
  assign perr_d     = perr_set | (perr_q & ~clr_err);
  assign parity_err = perr_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sync_q  <= 2'b11;
      div_q   <= '0;
      sc_q    <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      smp_q   <= 2'b11;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbad_q  <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], rxd};
      div_q   <= div_d;
      sc_q    <= sc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      smp_q   <= smp_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
      pbad_q  <= pbad_d;
      perr_q  <= perr_d;
`endif
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (shift_q),
    .pop_i   (rd_en),
    .data_o  (rd_data),
    .count_o (fifo_count),
    .drop_o  (fifo_drop)
  );

  assign data_ready = (fifo_count != '0);
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed and random frames against a queue-based
// receiver model; DIV=1 so one bit lasts OVERSAMPLE clocks.
module tb_uart_rx_core;

  localparam int unsigned DEPTH = 4;
  localparam int BIT = 16;

  logic       clk = 1'b0;
  logic       rst, rxd, rd_en, clr_err;
  logic [7:0] rd_data;
  logic       data_ready, frame_err, overrun;
  logic [$clog2(DEPTH):0] fifo_count;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx_core #(
    .CLK_FREQ   (1600000),
    .BAUD       (100000),
    .OVERSAMPLE (16),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .rd_en      (rd_en),
    .clr_err    (clr_err),
    .rd_data    (rd_data),
    .data_ready (data_ready),
    .fifo_count (fifo_count),
    .frame_err  (frame_err),
    .overrun    (overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int ferr_rises = 0;
  logic fe_prev = 1'b0;

  logic [7:0] q[$];
  logic m_ferr = 1'b0;
  logic m_ovr  = 1'b0;

  always @(negedge clk) begin
    if (frame_err && !fe_prev) ferr_rises++;
    fe_prev = frame_err;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // A received frame with a good stop bit lands in the FIFO unless full.
  task automatic model_rx(input logic [7:0] b);
    if (q.size() < DEPTH) q.push_back(b);
    else m_ovr = 1'b1;
  endtask

  task automatic check_state(input string tag);
    logic [7:0] head;
    head = (q.size() != 0) ? q[0] : 8'h00;
    chk({tag, ".ready"}, 32'(data_ready), 32'(q.size() != 0));
    chk({tag, ".count"}, 32'(fifo_count), 32'(q.size()));
    chk({tag, ".data"},  32'(rd_data),    32'(head));
    chk({tag, ".ferr"},  32'(frame_err),  32'(m_ferr));
    chk({tag, ".ovr"},   32'(overrun),    32'(m_ovr));
  endtask

  task automatic pop_check(input string tag);
    check_state(tag);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    if (q.size() != 0) q.delete(0);
  endtask

  task automatic clear_errs();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
  endtask

  // Called at a negedge; leaves rxd at the stop-bit level.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    idle(BIT);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      idle(BIT);
    end
    rxd = stop;
    idle(BIT);
  endtask

  initial begin
    logic [7:0] b;
    int n;
    rst = 1'b1; rxd = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(2);
    check_state("reset");

    send_frame(8'h55, 1'b1); model_rx(8'h55);
    idle(4);
    pop_check("f55");
    check_state("f55_popped");

    send_frame(8'hA3, 1'b1); model_rx(8'hA3);
    send_frame(8'h0F, 1'b1); model_rx(8'h0F);
    send_frame(8'hFF, 1'b1); model_rx(8'hFF);
    idle(4);
    for (int i = 0; i < 3; i++) pop_check($sformatf("b2b%0d", i));
    check_state("b2b_empty");

    rxd = 1'b0; idle(5); rxd = 1'b1;
    idle(3 * BIT);
    check_state("glitch");

    send_frame(8'h12, 1'b0);
    idle(40 * BIT);
    rxd = 1'b1;
    m_ferr = 1'b1;
    idle(2 * BIT);
    check_state("break");
    chk("ferr_once", 32'(ferr_rises), 32'd1);
    send_frame(8'h34, 1'b1); model_rx(8'h34);
    idle(4);
    pop_check("after_break");
    clear_errs();
    check_state("ferr_clr");

    for (int it = 0; it < 5; it++) begin
      n = int'($urandom_range(1, 3));
      for (int j = 0; j < n; j++) begin
        b = 8'($urandom);
        send_frame(b, 1'b1); model_rx(b);
      end
      idle(4 + int'($urandom_range(0, 20)));
      for (int j = 0; j < n; j++) pop_check($sformatf("rnd%0d_%0d", it, j));
      check_state($sformatf("rnd%0d_empty", it));
    end

    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1); model_rx(8'(i));
    end
    idle(4);
    check_state("ovr_full");
    clear_errs();
    check_state("ovr_clr");
    // rd_en lands on the push edge: start at negedge 0, stop sample at 156.
    fork
      send_frame(8'h06, 1'b1);
      begin
        idle(156);
        rd_en = 1'b1;
        idle(1);
        rd_en = 1'b0;
      end
    join
    q.delete(0);
    model_rx(8'h06);
    idle(4);
    check_state("push_pop_full");

    rxd = 1'b0;
    idle(BIT);
    b = 8'h77;
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      idle(BIT);
    end
    rst = 1'b1;
    idle(2);
    rxd = 1'b1;
    rst = 1'b0;
    q.delete();
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    idle(2 * BIT);
    check_state("mid_rst");
    send_frame(8'h88, 1'b1); model_rx(8'h88);
    idle(4);
    pop_check("after_rst");
    check_state("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
